// File: rtl/configs_loader_if.sv
// Handshake and latch-bank bus between the configuration source, the loader and the latch bank.
interface configs_loader_if #(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 41
);
    logic                  io_start;
    logic                  io_cfg_valid;
    logic                  io_cfg_ready;
    logic [WORD_WIDTH-1:0] io_cfg_bits;
    logic [WORD_WIDTH-1:0] io_d_out;
    logic [NUM_WORDS-1:0]  io_configs_en;
    logic                  io_busy;
    logic                  io_done;
    logic                  io_ok;

    modport master (
        output io_start, io_cfg_valid, io_cfg_bits,
        input  io_cfg_ready, io_d_out, io_configs_en, io_busy, io_done, io_ok
    );

    modport slave (
        input  io_start, io_cfg_valid, io_cfg_bits,
        output io_cfg_ready, io_d_out, io_configs_en, io_busy, io_done, io_ok
    );
endinterface

// File: rtl/configs_loader.sv
// Streams configuration words into the latch bank one slice at a time and checks a trailing XOR checksum.
//
// state  | meaning
// IDLE   | waiting for io_start after reset
// WAIT   | ready for the next data word or the checksum word
// STROBE | enable bit <count> high, d_out carries the word
// HOLD   | enables low, d_out held while the latch closes
// DONE   | load finished, io_ok reports the checksum result
module configs_loader #(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_WORDS  = 41
) (
    input  logic             clk,
    input  logic             reset,
    configs_loader_if.slave  cfg
);
    localparam int CW = $clog2(NUM_WORDS + 1);
    localparam logic [CW-1:0]        LAST_COUNT = CW'(NUM_WORDS);
    localparam logic [NUM_WORDS-1:0] EN_ONE     = NUM_WORDS'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            state;
    logic [WORD_WIDTH-1:0] d_reg;
    logic [CW-1:0]         count;
    logic [WORD_WIDTH-1:0] csum;
    logic                  done;
    logic                  ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            d_reg <= '0;
            count <= '0;
            csum  <= '0;
            done  <= 1'b0;
            ok    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (cfg.io_start) begin
                        state <= S_WAIT;
                        count <= '0;
                        csum  <= '0;
                        done  <= 1'b0;
                        ok    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (cfg.io_cfg_valid) begin
                        if (count < LAST_COUNT) begin
                            d_reg <= cfg.io_cfg_bits;
                            csum  <= csum ^ cfg.io_cfg_bits;
                            state <= S_STROBE;
                        end else begin
                            // trailing checksum word; d_reg keeps the last data word
                            ok    <= (csum == cfg.io_cfg_bits);
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_STROBE: state <= S_HOLD;
                S_HOLD: begin
                    count <= count + CW'(1);
                    state <= S_WAIT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg.io_cfg_ready  = (state == S_WAIT);
        cfg.io_busy       = (state == S_WAIT) || (state == S_STROBE) || (state == S_HOLD);
        cfg.io_configs_en = (state == S_STROBE) ? (EN_ONE << count) : '0;
        cfg.io_d_out      = d_reg;
        cfg.io_done       = done;
        cfg.io_ok         = ok;
    end
endmodule

// File: tb/tb_configs_loader.sv
// Directed bench for configs_loader: full loads, bad checksum, upstream gaps, ignored start, mid-load reset.
module tb_configs_loader;
    localparam int WW = 32;
    localparam int NW = 41;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    configs_loader_if #(.WORD_WIDTH(WW), .NUM_WORDS(NW)) bus ();

    configs_loader #(.WORD_WIDTH(WW), .NUM_WORDS(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .cfg   (bus.slave)
    );

    int passed = 0;
    int total  = 0;
    int ncyc   = 0;
    int start_cyc = 0;
    int en_q[$];
    logic [WW-1:0] dout_q[$];
    logic [NW-1:0] prev_en = '0;
    logic [WW-1:0] prev_dout = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Records every enable pulse and checks bus-level invariants each cycle.
    always @(negedge clk) begin
        int idx;
        ncyc++;
        if (bus.io_configs_en != '0) begin
            chk("en_onehot", 64'($onehot(bus.io_configs_en)), 64'd1);
            chk("ready_during_en", 64'(bus.io_cfg_ready), 64'd0);
            idx = -1;
            for (int i = 0; i < NW; i++) if (bus.io_configs_en[i]) idx = i;
            en_q.push_back(idx);
            dout_q.push_back(bus.io_d_out);
        end
        if (prev_en != '0 && !reset)
            chk("dout_stable_hold", 64'(bus.io_d_out), 64'(prev_dout));
        if (bus.io_cfg_ready && !bus.io_busy)
            chk("ready_outside_wait", 64'(bus.io_busy), 64'd1);
        prev_en   = bus.io_configs_en;
        prev_dout = bus.io_d_out;
    end

    task automatic pulse_start();
        bus.io_start = 1'b1;
        start_cyc = ncyc;
        @(posedge clk); #1;
        bus.io_start = 1'b0;
        chk("start_ready", 64'(bus.io_cfg_ready), 64'd1);
        chk("start_busy", 64'(bus.io_busy), 64'd1);
        chk("start_done_clr", 64'(bus.io_done), 64'd0);
        chk("start_ok_clr", 64'(bus.io_ok), 64'd0);
    endtask

    task automatic send_word(input logic [WW-1:0] data, input int gap);
        int n;
        repeat (gap) begin @(posedge clk); #1; end
        bus.io_cfg_valid = 1'b1;
        bus.io_cfg_bits  = data;
        n = 0;
        @(negedge clk);
        while (!bus.io_cfg_ready && n < 200) begin n++; @(negedge clk); end
        if (!bus.io_cfg_ready) chk("handshake_timeout", 64'(bus.io_cfg_ready), 64'd1);
        @(posedge clk); #1;
        bus.io_cfg_valid = 1'b0;
    endtask

    task automatic verify_seq(input int n_exp);
        chk("en_pulse_count", 64'(en_q.size()), 64'(n_exp));
        for (int k = 0; k < n_exp && k < en_q.size(); k++) begin
            chk("en_order", 64'(en_q[k]), 64'(k));
            chk("dout_during_en", 64'(dout_q[k]), 64'(k + 1));
        end
    endtask

    // Words are k+1 for k = 0..40; XOR of 1..41 is 0x00000001.
    task automatic run_load(input logic [WW-1:0] csum_word, input logic use_gaps,
                            input int start_at, input int reset_at, input logic exp_ok,
                            input logic chk_latency);
        en_q.delete();
        dout_q.delete();
        pulse_start();
        for (int k = 0; k < NW; k++) begin
            send_word(WW'(k + 1), use_gaps ? (k * 7 + 3) % 6 : 0);
            if (k == start_at) begin
                @(posedge clk); #1;
                bus.io_start = 1'b1;
                chk("hold_busy", 64'(bus.io_busy), 64'd1);
                @(posedge clk); #1;
                bus.io_start = 1'b0;
            end
            if (k == reset_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                chk("rst_en", 64'(bus.io_configs_en), 64'd0);
                chk("rst_busy", 64'(bus.io_busy), 64'd0);
                chk("rst_dout", 64'(bus.io_d_out), 64'd0);
                chk("rst_ready", 64'(bus.io_cfg_ready), 64'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                verify_seq(reset_at + 1);
                return;
            end
        end
        send_word(csum_word, 0);
        chk("done", 64'(bus.io_done), 64'd1);
        chk("busy_at_done", 64'(bus.io_busy), 64'd0);
        chk("ok", 64'(bus.io_ok), 64'(exp_ok));
        if (chk_latency) chk("load_cycles", 64'(ncyc - start_cyc), 64'd125);
        verify_seq(NW);
        repeat (3) begin @(posedge clk); #1; end
        chk("done_level", 64'(bus.io_done), 64'd1);
    endtask

    initial begin
        bus.io_start     = 1'b0;
        bus.io_cfg_valid = 1'b0;
        bus.io_cfg_bits  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state_ready", 64'(bus.io_cfg_ready), 64'd0);
        chk("rst_state_en", 64'(bus.io_configs_en), 64'd0);
        chk("rst_state_dout", 64'(bus.io_d_out), 64'd0);
        chk("rst_state_busy", 64'(bus.io_busy), 64'd0);
        chk("rst_state_done", 64'(bus.io_done), 64'd0);
        chk("rst_state_ok", 64'(bus.io_ok), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        // valid in IDLE must not be consumed
        bus.io_cfg_valid = 1'b1;
        bus.io_cfg_bits  = 32'hFFFF_FFFF;
        repeat (2) begin @(posedge clk); #1; end
        chk("idle_ignores_valid", 64'(bus.io_d_out), 64'd0);
        bus.io_cfg_valid = 1'b0;

        run_load(32'h0000_0001, 1'b0, -1, -1, 1'b1, 1'b1);
        run_load(32'hDEAD_BEEF, 1'b0, -1, -1, 1'b0, 1'b1);
        run_load(32'h0000_0001, 1'b1,  7, -1, 1'b1, 1'b0);
        run_load(32'h0000_0001, 1'b0, -1, 20, 1'b1, 1'b0);
        chk("post_rst_done", 64'(bus.io_done), 64'd0);
        chk("post_rst_ok", 64'(bus.io_ok), 64'd0);
        run_load(32'h0000_0029, 1'b0, -1, -1, 1'b0, 1'b1);
        run_load(32'h0000_0001, 1'b1, -1, -1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
